bus16_master: RTL
=================

# bus16_master

Synchronous initiator for the team's 16-bit register bus. It accepts one read or write command at a time over a valid/ready handshake and drives a single-cycle chip-select transaction to a bus responder such as a register bank. For reads it waits for the responder's read-data-valid, with a bounded timeout. It returns one response per command. It sits between a command source (UART bridge, sequencer) and the responder-side register blocks.

## Interface
Parameters:
- g_TIMEOUT, 16: maximum cycles to wait for i_Bus_Rd_DV after a read CS cycle; legal range 1..255.

Ports:
- i_Bus_Clk  in  1  bus clock. One clock for the whole block.
- i_Bus_Rst  in  1  reset. Synchronous and active-high.
- i_Cmd_DV  in  1  command valid.
- o_Cmd_Ready  out  1  block can accept a command; high only in IDLE.
- i_Cmd_Wr_Rd_n  in  1  1 = write, 0 = read.
- i_Cmd_Addr8  in  8  byte address.
- i_Cmd_Wr_Data  in  16  write data; ignored for reads.
- o_Bus_CS  out  1  chip select; exactly one cycle per transaction.
- o_Bus_Wr_Rd_n  out  1  direction, valid while o_Bus_CS=1.
- o_Bus_Addr8  out  8  address, valid while o_Bus_CS=1.
- o_Bus_Wr_Data  out  16  write data, valid while o_Bus_CS=1.
- i_Bus_Rd_Data  in  16  responder read data, valid with i_Bus_Rd_DV.
- i_Bus_Rd_DV  in  1  responder read data valid.
- o_Rsp_DV  out  1  one-cycle response pulse, one per accepted command.
- o_Rsp_Data  out  16  read data, or 0 for writes and timeouts; held until the next o_Rsp_DV.
- o_Rsp_Timeout  out  1  set with o_Rsp_DV when a read timed out.
- o_Timeout_Count  out  8  saturating count of timeouts since reset.

## Operation
- States: IDLE, ISSUE, WAIT_RD.
- IDLE
  - o_Cmd_Ready=1.
  - On i_Cmd_DV=1: register Wr_Rd_n, Addr8 and Wr_Data onto the bus outputs, then go to ISSUE.
- ISSUE
  - o_Bus_CS=1 for this single cycle.
  - Write: pulse o_Rsp_DV next cycle with Data=0 and Timeout=0, then return to IDLE.
  - Read: clear the wait counter and go to WAIT_RD.
- WAIT_RD
  - Each cycle, if i_Bus_Rd_DV=1: capture i_Bus_Rd_Data into o_Rsp_Data, pulse o_Rsp_DV with Timeout=0, and go to IDLE.
  - Otherwise increment the counter.
  - When g_TIMEOUT cycles have elapsed without DV: pulse o_Rsp_DV with Timeout=1 and Data=0, increment o_Timeout_Count (saturates at 255), and go to IDLE.
- If i_Bus_Rd_DV arrives in the same cycle the counter expires, DV wins: success response, no timeout.
- i_Bus_Rd_DV is ignored in IDLE and ISSUE, and during write transactions. Stray pulses are dropped silently.
- Bus address/data/direction outputs hold their last values after CS drops. Only o_Bus_CS qualifies them.
- Commands presented while o_Cmd_Ready=0 are not accepted. The source must hold i_Cmd_DV and its fields until a cycle with Ready=1.

## Timing
- All outputs are registered, except o_Cmd_Ready, which is decoded from the state.
- Reset values: state IDLE; o_Bus_CS=0, o_Bus_Wr_Rd_n=0, o_Bus_Addr8=0, o_Bus_Wr_Data=0, o_Rsp_DV=0, o_Rsp_Data=0, o_Rsp_Timeout=0, o_Timeout_Count=0.
- Cycle numbering: command accepted at cycle 0 (DV and Ready both high).
  - CS high in cycle 1.
  - Write: o_Rsp_DV in cycle 2; Ready high again in cycle 2.
  - Read, responder DV in cycle k (2 ≤ k ≤ 1+g_TIMEOUT): o_Rsp_DV in cycle k+1; Ready high in cycle k+1.
  - Read timeout: no DV in cycles 2..1+g_TIMEOUT, so o_Rsp_DV with Timeout=1 in cycle 2+g_TIMEOUT.
- A command can be accepted in the same cycle o_Rsp_DV pulses. Back-to-back writes therefore issue CS every 2 cycles.
- Reset asserted mid-transaction: state returns to IDLE on the next edge and no response is emitted for the aborted command. o_Bus_CS is 0 from the cycle after reset is sampled.

## Test plan
- Write 0x02 with data 0x987B.
  - Expect CS=1 only in cycle 1 with Wr_Rd_n=1, Addr=0x02, Data=0x987B.
  - Expect Rsp_DV in cycle 2 with Data=0 and Timeout=0.
- Read 0x02 against a register-bank responder after that write.
  - Responder DV in cycle 2 with 0x987B.
  - Expect Rsp_DV in cycle 3 with Data=0x987B and Timeout=0.
- Read 0x08 with the responder never asserting DV (g_TIMEOUT=16).
  - Expect Rsp_DV in cycle 18 with Timeout=1 and Data=0; o_Timeout_Count=1.
- Read with the model asserting DV exactly in cycle 17, data 0xABCD.
  - Expect a success response in cycle 18 with Data=0xABCD, Timeout=0, and the count unchanged.
- Hold i_Cmd_DV high for writes to 0x00 then 0x04.
  - Expect the second command accepted in cycle 2 and CS pulses in cycles 1 and 3.
  - Pulse i_Bus_Rd_DV in IDLE and expect no Rsp_DV.
- Assert reset for one cycle in WAIT_RD.
  - Expect no Rsp_DV, Ready=1 the cycle after reset releases, and all outputs at reset values.
  - Expect the next read to complete normally.

Source files
------------

// File: rtl/bus16_master.sv
// Single-outstanding initiator for the 16-bit register bus: accepts a command,
// drives one chip-select cycle, and returns one response (read data or timeout).
module bus16_master #(
  parameter int unsigned g_TIMEOUT = 16
) (
  input  logic        i_Bus_Clk,
  input  logic        i_Bus_Rst,
  input  logic        i_Cmd_DV,
  output logic        o_Cmd_Ready,
  input  logic        i_Cmd_Wr_Rd_n,
  input  logic [7:0]  i_Cmd_Addr8,
  input  logic [15:0] i_Cmd_Wr_Data,
  output logic        o_Bus_CS,
  output logic        o_Bus_Wr_Rd_n,
  output logic [7:0]  o_Bus_Addr8,
  output logic [15:0] o_Bus_Wr_Data,
  input  logic [15:0] i_Bus_Rd_Data,
  input  logic        i_Bus_Rd_DV,
  output logic        o_Rsp_DV,
  output logic [15:0] o_Rsp_Data,
  output logic        o_Rsp_Timeout,
  output logic [7:0]  o_Timeout_Count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD
  } state_e;

  // Counter value seen in the last waiting cycle before the read gives up.
  localparam logic [7:0] LAST_WAIT = 8'(g_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        bus_cs_q, bus_cs_d;
  logic        bus_wr_rd_n_q, bus_wr_rd_n_d;
  logic [7:0]  bus_addr_q, bus_addr_d;
  logic [15:0] bus_wr_data_q, bus_wr_data_d;
  logic        rsp_dv_q, rsp_dv_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [7:0]  timeout_cnt_q, timeout_cnt_d;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    bus_cs_d      = 1'b0;
    bus_wr_rd_n_d = bus_wr_rd_n_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rsp_dv_d      = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    timeout_cnt_d = timeout_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_Cmd_DV) begin
          bus_cs_d      = 1'b1;
          bus_wr_rd_n_d = i_Cmd_Wr_Rd_n;
          bus_addr_d    = i_Cmd_Addr8;
          bus_wr_data_d = i_Cmd_Wr_Data;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus_wr_rd_n_q) begin
          rsp_dv_d      = 1'b1;
          rsp_data_d    = 16'h0000;
          rsp_timeout_d = 1'b0;
          state_d       = S_IDLE;
        end else begin
          wait_cnt_d = 8'd0;
          state_d    = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        // Data arriving in the expiry cycle still counts as a success.
        if (i_Bus_Rd_DV) begin
          rsp_dv_d      = 1'b1;
          rsp_data_d    = i_Bus_Rd_Data;
          rsp_timeout_d = 1'b0;
          state_d       = S_IDLE;
        end else if (wait_cnt_q == LAST_WAIT) begin
          rsp_dv_d      = 1'b1;
          rsp_data_d    = 16'h0000;
          rsp_timeout_d = 1'b1;
          if (timeout_cnt_q != 8'hFF) begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
          end
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= 8'd0;
      bus_cs_q      <= 1'b0;
      bus_wr_rd_n_q <= 1'b0;
      bus_addr_q    <= 8'd0;
      bus_wr_data_q <= 16'h0000;
      rsp_dv_q      <= 1'b0;
      rsp_data_q    <= 16'h0000;
      rsp_timeout_q <= 1'b0;
      timeout_cnt_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      bus_cs_q      <= bus_cs_d;
      bus_wr_rd_n_q <= bus_wr_rd_n_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rsp_dv_q      <= rsp_dv_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign o_Cmd_Ready     = (state_q == S_IDLE);
  assign o_Bus_CS        = bus_cs_q;
  assign o_Bus_Wr_Rd_n   = bus_wr_rd_n_q;
  assign o_Bus_Addr8     = bus_addr_q;
  assign o_Bus_Wr_Data   = bus_wr_data_q;
  assign o_Rsp_DV        = rsp_dv_q;
  assign o_Rsp_Data      = rsp_data_q;
  assign o_Rsp_Timeout   = rsp_timeout_q;
  assign o_Timeout_Count = timeout_cnt_q;

endmodule
